// File: rtl/spi_slave_regfile.sv
// SPI mode-0 peripheral with a byte-wide register file and a local access port.
// Optional build macro: SPI_SLAVE_DEVID_EN (address 0 becomes a read-only device ID).
module spi_slave_regfile #(
  parameter int         REG_DEPTH   = 64,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID       = 8'hAD,
  localparam int        AW          = $clog2(REG_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sclk,
  input  logic          mosi,
  input  logic          cs,
  output logic          miso,
  input  logic          loc_we,
  input  logic [AW-1:0] loc_addr,
  input  logic [7:0]    loc_wdata,
  output logic [7:0]    loc_rdata,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   sclk_prev_q;

  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    tx_q, tx_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rd_q, rd_d;
  logic          miso_q, miso_d;
  logic          stb_q, stb_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          spi_we;

  logic [7:0] regs_q [REG_DEPTH];

  logic          sclk_s, mosi_s, cs_s;
  logic          rise, fall, byte_done;
  logic [7:0]    rx_byte;
  logic [AW-1:0] addr_in;
  logic          loc_ok, spi_ok;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign rise      = sclk_s & ~sclk_prev_q;
  assign fall      = ~sclk_s & sclk_prev_q;
  assign byte_done = rise && (bitcnt_q == 3'd7);
  assign rx_byte   = {rx_q[6:0], mosi_s};
  assign addr_in   = rx_byte[AW-1:0];

`ifdef SPI_SLAVE_DEVID_EN
  function automatic logic [7:0] rd_reg(input logic [AW-1:0] a);
    return (a == '0) ? DEVID : regs_q[a];
  endfunction
  assign loc_ok = loc_we && (loc_addr != '0);
  assign spi_ok = spi_we && (ptr_q != '0);
`else
  function automatic logic [7:0] rd_reg(input logic [AW-1:0] a);
    return regs_q[a];
  endfunction
  logic unused_devid;
  assign unused_devid = ^DEVID;
  assign loc_ok = loc_we;
  assign spi_ok = spi_we;
`endif

  assign loc_rdata = rd_reg(loc_addr);
  assign miso      = miso_q;
  assign wr_strobe = stb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = ~cs_s;

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    rd_d      = rd_q;
    miso_d    = 1'b0;
    stb_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    spi_we    = 1'b0;
    if (cs_s) begin
      state_d  = IDLE;
      bitcnt_d = '0;
    end else begin
      if (rise && state_q != IDLE) begin
        rx_d     = rx_byte;
        bitcnt_d = bitcnt_q + 3'd1;
      end
      unique case (state_q)
        IDLE: begin
          state_d  = CMD;
          bitcnt_d = '0;
        end
        CMD: begin
          if (byte_done) begin
            unique case (1'b1)
              rx_byte == 8'h0A: begin
                state_d = ADDR;
                rd_d    = 1'b0;
              end
              rx_byte == 8'h0B: begin
                state_d = ADDR;
                rd_d    = 1'b1;
              end
              default: state_d = IGNORE;
            endcase
          end
        end
        ADDR: begin
          if (byte_done) begin
            if (rd_q) begin
              tx_d    = rd_reg(addr_in);
              ptr_d   = addr_in + 1'b1;
              state_d = RDATA;
            end else begin
              ptr_d   = addr_in;
              state_d = WDATA;
            end
          end
        end
        WDATA: begin
          if (byte_done) begin
            spi_we    = 1'b1;
            stb_d     = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = rx_byte;
            ptr_d     = ptr_q + 1'b1;
          end
        end
        RDATA: begin
          miso_d = miso_q;
          if (fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          // Reload exactly as the next byte starts; only its first fall shifts it out
          if (byte_done) begin
            tx_d  = rd_reg(ptr_q);
            ptr_d = ptr_q + 1'b1;
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      bitcnt_q    <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      rd_q        <= 1'b0;
      miso_q      <= 1'b0;
      stb_q       <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_prev_q <= sclk_s;
      bitcnt_q    <= bitcnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rd_q        <= rd_d;
      miso_q      <= miso_d;
      stb_q       <= stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      // SPI write is last so it wins a same-address collision
      if (loc_ok) regs_q[loc_addr] <= loc_wdata;
      if (spi_ok) regs_q[ptr_q] <= rx_byte;
    end
  end

endmodule
